// File: rtl/weight_bias_fetcher.sv
// rtl/weight_bias_fetcher.sv - burst read engine feeding the conv weight/bias buffer
//
// Purpose:
//   Accepts a fetch task (base byte address, beat count), splits it into
//   bursts of at most BURST_LEN beats on the memory read port, and forwards
//   each returned beat to the weight/bias buffer one cycle after it arrives.
//   A new burst is only requested while the buffer reports room
//   (weight_buffer_ready); only one burst is ever outstanding.
//
// Ports:
//   system_clk, rst         clock, synchronous active-high reset
//   task_start              start pulse, only honoured in IDLE
//   task_base_addr          first beat byte address (beat aligned)
//   task_beats              number of beats to fetch (0 = empty task)
//   task_abort              cancel the running task; no task_done follows
//   task_busy               high whenever the engine is not IDLE
//   task_done               one-cycle pulse when a task is fully forwarded
//   protocol_err            sticky flag for beats arriving with no burst open
//   mem_rd_req/addr/len     burst request (len = beats-1), held until ack
//   mem_rd_ack              request accepted
//   mem_rd_data/valid       returned beats, no backpressure
//   weight_buffer_ready     buffer has room for at least one more burst
//   weight_and_bias_data    registered beat to the buffer
//   weight_and_bias_valid   beat valid to the buffer

module weight_bias_fetcher #(
  parameter int MEM_DATA_WIDTH = 512,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 20,
  parameter int BURST_LEN      = 16
) (
  input  logic                      system_clk,
  input  logic                      rst,
  input  logic                      task_start,
  input  logic [ADDR_WIDTH-1:0]     task_base_addr,
  input  logic [LEN_WIDTH-1:0]      task_beats,
  input  logic                      task_abort,
  output logic                      task_busy,
  output logic                      task_done,
  output logic                      protocol_err,
  output logic                      mem_rd_req,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  output logic [7:0]                mem_rd_len,
  input  logic                      mem_rd_ack,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  input  logic                      mem_rd_valid,
  input  logic                      weight_buffer_ready,
  output logic [MEM_DATA_WIDTH-1:0] weight_and_bias_data,
  output logic                      weight_and_bias_valid
);

  localparam int BEAT_BYTES = MEM_DATA_WIDTH / 8;
  // Beat counter must hold a full 256-beat burst.
  localparam int CNT_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic                      req_q, req_d;
  logic [7:0]                len_q, len_d;
  logic                      perr_q, perr_d;
  logic [MEM_DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                      wb_valid_q, wb_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [CNT_W-1:0]          next_burst;
  logic [CNT_W-1:0]          acked_beats;
  logic [ADDR_WIDTH-1:0]     addr_step;
  logic                      last_beat;

  // Size of the burst about to be requested, and of the one being acked.
  always_comb begin
    if (remaining_q > LEN_WIDTH'(BURST_LEN)) begin
      next_burst = CNT_W'(BURST_LEN);
    end else begin
      next_burst = CNT_W'(remaining_q);
    end
    acked_beats = CNT_W'(len_q) + CNT_W'(1);
    addr_step   = ADDR_WIDTH'(acked_beats) * ADDR_WIDTH'(BEAT_BYTES);
    last_beat   = (beat_cnt_q == CNT_W'(1));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    req_d       = req_q;
    len_d       = len_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = 1'b0;
    perr_d      = perr_q;

    // A beat with no burst open is dropped and flagged.
    if (mem_rd_valid &&
        (state_q == S_IDLE || state_q == S_REQ || state_q == S_DONE)) begin
      perr_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (task_start) begin
          if (task_beats != '0) begin
            addr_d      = task_base_addr;
            remaining_d = task_beats;
            state_d     = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_REQ: begin
        if (task_abort) begin
          req_d = 1'b0;
          // An ack in the abort cycle still commits memory to a burst,
          // so its beats must be swallowed before going idle.
          if (req_q && mem_rd_ack) begin
            beat_cnt_d = acked_beats;
            state_d    = S_DRAIN;
          end else begin
            state_d = S_IDLE;
          end
        end else if (req_q) begin
          // Request stays frozen until accepted, even if ready drops.
          if (mem_rd_ack) begin
            req_d       = 1'b0;
            beat_cnt_d  = acked_beats;
            addr_d      = addr_q + addr_step;
            remaining_d = remaining_q - LEN_WIDTH'(acked_beats);
            state_d     = S_DATA;
          end
        end else if (weight_buffer_ready) begin
          req_d = 1'b1;
          len_d = 8'(next_burst - CNT_W'(1));
        end
      end

      S_DATA: begin
        if (mem_rd_valid) begin
          beat_cnt_d = beat_cnt_q - CNT_W'(1);
          if (task_abort) begin
            state_d = last_beat ? S_IDLE : S_DRAIN;
          end else begin
            wb_data_d  = mem_rd_data;
            wb_valid_d = 1'b1;
            if (last_beat) begin
              state_d = (remaining_q != '0) ? S_REQ : S_DONE;
            end
          end
        end else if (task_abort) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (mem_rd_valid) begin
          beat_cnt_d = beat_cnt_q - CNT_W'(1);
          if (last_beat) begin
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      req_q       <= 1'b0;
      len_q       <= '0;
      perr_q      <= 1'b0;
      wb_data_q   <= '0;
      wb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      req_q       <= req_d;
      len_q       <= len_d;
      perr_q      <= perr_d;
      wb_data_q   <= wb_data_d;
      wb_valid_q  <= wb_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign task_busy             = busy_q;
  // An abort landing on the DONE cycle cancels the completion pulse.
  assign task_done             = done_q & ~task_abort;
  assign protocol_err          = perr_q;
  assign mem_rd_req            = req_q;
  assign mem_rd_addr           = addr_q;
  assign mem_rd_len            = len_q;
  assign weight_and_bias_data  = wb_data_q;
  assign weight_and_bias_valid = wb_valid_q;

endmodule

// File: tb/tb_weight_bias_fetcher.sv
// tb/tb_weight_bias_fetcher.sv - self-checking bench for weight_bias_fetcher
module tb_weight_bias_fetcher;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int LW = 20;
  localparam int BL = 16;

  logic          system_clk = 1'b0;
  logic          rst;
  logic          task_start;
  logic [AW-1:0] task_base_addr;
  logic [LW-1:0] task_beats;
  logic          task_abort;
  logic          task_busy;
  logic          task_done;
  logic          protocol_err;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_len;
  logic          mem_rd_ack;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic          weight_buffer_ready;
  logic [DW-1:0] weight_and_bias_data;
  logic          weight_and_bias_valid;

  always #5 system_clk = ~system_clk;

  weight_bias_fetcher #(
    .MEM_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BURST_LEN(BL)
  ) dut (
    .system_clk(system_clk), .rst(rst),
    .task_start(task_start), .task_base_addr(task_base_addr),
    .task_beats(task_beats), .task_abort(task_abort),
    .task_busy(task_busy), .task_done(task_done), .protocol_err(protocol_err),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .weight_buffer_ready(weight_buffer_ready),
    .weight_and_bias_data(weight_and_bias_data),
    .weight_and_bias_valid(weight_and_bias_valid)
  );

  int errors = 0;
  int checks = 0;

  // Knobs, written by the main sequence only.
  int ack_dly    = 0;
  bit gaps       = 1'b0;
  bit ready_rand = 1'b0;
  bit ready_val  = 1'b1;
  int gap_after  = -1;
  int stray_req  = 0;

  // Memory responder / monitor state, written by that process only.
  logic [AW-1:0] got_addr[$];
  logic [7:0]    got_len[$];
  logic [DW-1:0] got_data[$];
  int            done_cnt = 0;
  int            lat_bad = 0;
  int            stable_bad = 0;
  int            early_bad = 0;
  int            beats_left = 0;
  int            delivered = 0;
  int            wait_cnt = 0;
  int            stray_done = 0;
  bit            gap_armed = 1'b0;
  bit            prev_req = 1'b0;
  logic [AW-1:0] held_addr = '0;
  logic [7:0]    held_len = '0;
  logic [AW-1:0] beat_addr = '0;

  logic          ready_edge = 1'b0;
  logic          mv_edge = 1'b0;
  logic [DW-1:0] md_edge = '0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = a ^ 32'h5A5A_0F0F;
    return {16{w}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge system_clk);
    #1;
  endtask

  // Input values the DUT actually sampled at each edge.
  always @(posedge system_clk) begin
    ready_edge <= weight_buffer_ready;
    mv_edge    <= mem_rd_valid;
    md_edge    <= mem_rd_data;
  end

  // Memory model and output monitor.
  initial begin
    mem_rd_ack = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    weight_buffer_ready = 1'b0;
    forever begin
      @(negedge system_clk);
      if (weight_and_bias_valid) begin
        got_data.push_back(weight_and_bias_data);
        if (!(mv_edge && md_edge == weight_and_bias_data)) lat_bad++;
      end
      if (task_done) done_cnt++;
      if (mem_rd_req && prev_req && (mem_rd_addr != held_addr || mem_rd_len != held_len)) stable_bad++;
      if (mem_rd_req && !prev_req && !ready_edge) early_bad++;
      prev_req = mem_rd_req;
      held_addr = mem_rd_addr;
      held_len = mem_rd_len;

      mem_rd_ack = 1'b0;
      mem_rd_valid = 1'b0;
      weight_buffer_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
      if (stray_done < stray_req) begin
        mem_rd_valid = 1'b1;
        mem_rd_data = pat(32'hDEAD_0000);
        stray_done++;
      end else if (beats_left > 0) begin
        if (gap_armed && delivered == gap_after) begin
          gap_armed = 1'b0;
        end else if (!(gaps && $urandom_range(0, 3) == 0)) begin
          mem_rd_valid = 1'b1;
          mem_rd_data = pat(beat_addr);
          beat_addr += 32'd64;
          beats_left--;
          delivered++;
        end
      end else if (mem_rd_req) begin
        if (wait_cnt >= ack_dly) begin
          mem_rd_ack = 1'b1;
          got_addr.push_back(mem_rd_addr);
          got_len.push_back(mem_rd_len);
          beat_addr = mem_rd_addr;
          beats_left = int'(mem_rd_len) + 1;
          delivered = 0;
          gap_armed = (gap_after >= 0);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Runs one task to completion and checks it against the burst-splitting rules.
  task automatic run_task(input logic [AW-1:0] base, input int beats, input int dly,
                          input bit gp, input bit rr, input int exp_nreq, input string tag);
    int r0, d0, dn0, lat0, st0, ea0, n, k, rem, b, bad;
    logic [AW-1:0] a;
    r0 = got_addr.size();
    d0 = got_data.size();
    dn0 = done_cnt;
    lat0 = lat_bad;
    st0 = stable_bad;
    ea0 = early_bad;
    ack_dly = dly;
    gaps = gp;
    ready_rand = rr;
    ready_val = 1'b1;
    task_base_addr = base;
    task_beats = LW'(beats);
    task_start = 1'b1;
    tick();
    task_start = 1'b0;
    for (n = 0; n < 4000 && (task_busy || beats_left != 0); n++) tick();
    ready_rand = 1'b0;
    check({tag, "_finished"}, (n < 4000), 1);

    a = base;
    rem = beats;
    k = 0;
    while (rem > 0) begin
      b = (rem > BL) ? BL : rem;
      if (r0 + k < got_addr.size()) begin
        check($sformatf("%s_req%0d_addr", tag, k), got_addr[r0+k], a);
        check($sformatf("%s_req%0d_len", tag, k), got_len[r0+k], b - 1);
      end
      a += 32'(b * 64);
      rem -= b;
      k++;
    end
    check({tag, "_nreq"}, got_addr.size() - r0, k);
    if (exp_nreq >= 0) check({tag, "_nreq_table"}, got_addr.size() - r0, exp_nreq);

    bad = 0;
    for (int i = 0; i < beats; i++) begin
      if (d0 + i < got_data.size() && got_data[d0+i] !== pat(base + 32'(i * 64))) bad++;
    end
    check({tag, "_nbeats"}, got_data.size() - d0, beats);
    check({tag, "_beat_data_bad"}, bad, 0);
    check({tag, "_done_pulses"}, done_cnt - dn0, 1);
    check({tag, "_latency_bad"}, lat_bad - lat0, 0);
    check({tag, "_req_unstable"}, stable_bad - st0, 0);
    check({tag, "_req_without_ready"}, early_bad - ea0, 0);
    check({tag, "_protocol_err"}, protocol_err, 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            beats;
    int            dly;
    bit            gp;
    bit            rr;
    int            exp_nreq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, dn0, n;
    bit saw;
    logic [AW-1:0] ra;
    logic [7:0] rl;

    vecs[0] = '{32'h0000_1000, 40, 0, 1'b0, 1'b0, 3};
    vecs[1] = '{32'h0000_2000, 16, 2, 1'b1, 1'b0, 1};
    vecs[2] = '{32'h0000_3000, 17, 1, 1'b0, 1'b1, 2};
    vecs[3] = '{32'h0000_4000, 1, 0, 1'b0, 1'b0, 1};
    vecs[4] = '{32'hFFFF_FC00, 20, 0, 1'b1, 1'b1, 2};
    vecs[5] = '{32'h0000_8000, 33, 3, 1'b1, 1'b1, 3};
    vecs[6] = '{32'h0001_0000, 256, 0, 1'b0, 1'b0, 16};

    rst = 1'b1;
    task_start = 1'b0;
    task_base_addr = '0;
    task_beats = '0;
    task_abort = 1'b0;
    tick();
    tick();
    check("reset_busy", task_busy, 0);
    check("reset_req", mem_rd_req, 0);
    check("reset_valid", weight_and_bias_valid, 0);
    check("reset_data", weight_and_bias_data, 0);
    check("reset_addr", mem_rd_addr, 0);
    check("reset_len", mem_rd_len, 0);
    check("reset_perr", protocol_err, 0);
    check("reset_done", task_done, 0);
    rst = 1'b0;
    tick();

    // Table vectors; entry 0 is the reference 40-beat fetch.
    for (int i = 0; i < 7; i++) begin
      r0 = got_addr.size();
      run_task(vecs[i].base, vecs[i].beats, vecs[i].dly, vecs[i].gp, vecs[i].rr,
               vecs[i].exp_nreq, $sformatf("vec%0d", i));
      if (i == 0 && got_addr.size() >= r0 + 3) begin
        check("t1_req0", {got_addr[r0], got_len[r0]}, {32'h0000_1000, 8'd15});
        check("t1_req1", {got_addr[r0+1], got_len[r0+1]}, {32'h0000_1400, 8'd15});
        check("t1_req2", {got_addr[r0+2], got_len[r0+2]}, {32'h0000_1800, 8'd7});
      end
      tick();
    end

    // Empty task: straight to DONE, no memory traffic.
    r0 = got_addr.size();
    dn0 = done_cnt;
    task_base_addr = 32'h0000_5000;
    task_beats = '0;
    task_start = 1'b1;
    tick();
    task_start = 1'b0;
    check("t2_done_high", task_done, 1);
    check("t2_busy_high", task_busy, 1);
    tick();
    check("t2_done_low", task_done, 0);
    check("t2_busy_low", task_busy, 0);
    tick();
    check("t2_no_req", got_addr.size() - r0, 0);
    check("t2_one_done", done_cnt - dn0, 1);

    // Buffer not ready: request withheld, then held stable while ready drops.
    ready_val = 1'b0;
    ack_dly = 3;
    gaps = 1'b0;
    d0 = got_data.size();
    task_base_addr = 32'h0000_6000;
    task_beats = LW'(16);
    task_start = 1'b1;
    tick();
    task_start = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_rd_req) saw = 1'b1;
      tick();
    end
    check("t3_no_req_while_not_ready", saw, 0);
    ready_val = 1'b1;
    for (n = 0; n < 20 && !mem_rd_req; n++) tick();
    check("t3_req_after_ready", mem_rd_req, 1);
    ready_val = 1'b0;
    ra = mem_rd_addr;
    rl = mem_rd_len;
    check("t3_req_addr_len", {ra, rl}, {32'h0000_6000, 8'd15});
    tick();
    tick();
    check("t3_req_held", mem_rd_req, 1);
    check("t3_addr_len_stable", {mem_rd_addr, mem_rd_len}, {ra, rl});
    ready_val = 1'b1;
    for (n = 0; n < 200 && (task_busy || beats_left != 0); n++) tick();
    check("t3_beats", got_data.size() - d0, 16);
    check("t3_stable_bad", stable_bad, 0);
    check("t3_early_bad", early_bad, 0);
    ack_dly = 0;

    // Abort after the 5th beat of a burst: 11 beats drained silently.
    d0 = got_data.size();
    dn0 = done_cnt;
    r0 = got_addr.size();
    gap_after = 5;
    task_base_addr = 32'h0000_7000;
    task_beats = LW'(32);
    task_start = 1'b1;
    tick();
    task_start = 1'b0;
    for (n = 0; n < 100 && beats_left != 11; n++) tick();
    check("t4_reached_5th_beat", beats_left, 11);
    tick();
    task_abort = 1'b1;
    tick();
    task_abort = 1'b0;
    for (n = 0; n < 100 && beats_left != 0; n++) tick();
    check("t4_busy_before_last_drain", task_busy, 1);
    tick();
    check("t4_idle_after_drain", task_busy, 0);
    check("t4_forwarded", got_data.size() - d0, 5);
    check("t4_no_done", done_cnt - dn0, 0);
    check("t4_one_req", got_addr.size() - r0, 1);
    check("t4_perr", protocol_err, 0);
    gap_after = -1;
    run_task(32'h0000_9000, 20, 1, 1'b1, 1'b0, 2, "t4_after");

    // Stray beat in IDLE.
    d0 = got_data.size();
    stray_req++;
    tick();
    tick();
    check("t5_perr_set", protocol_err, 1);
    check("t5_nothing_forwarded", got_data.size() - d0, 0);
    for (int i = 0; i < 5; i++) tick();
    check("t5_perr_sticky", protocol_err, 1);
    do_reset();
    check("t5_perr_cleared", protocol_err, 0);

    // Reset in the middle of a burst.
    task_base_addr = 32'h0000_A000;
    task_beats = LW'(16);
    task_start = 1'b1;
    tick();
    task_start = 1'b0;
    for (n = 0; n < 100 && beats_left != 12; n++) tick();
    check("t6_reached_data", beats_left, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", task_busy, 0);
    check("t6_req", mem_rd_req, 0);
    check("t6_valid", weight_and_bias_valid, 0);
    check("t6_data", weight_and_bias_data, 0);
    check("t6_addr_len", {mem_rd_addr, mem_rd_len}, 0);
    check("t6_done", task_done, 0);
    for (n = 0; n < 100 && beats_left != 0; n++) tick();
    tick();
    tick();
    check("t6_late_beats_perr", protocol_err, 1);
    do_reset();

    // Randomized tasks against the burst-splitting model.
    for (int i = 0; i < 8; i++) begin
      run_task($urandom & 32'hFFFF_FFC0, $urandom_range(1, 60), $urandom_range(0, 3),
               1'b1, 1'b1, -1, $sformatf("rnd%0d", i));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
